// File: rtl/tdfc_stream_queue.sv
// Elastic FIFO for one TDF stream: {e,d} tokens in on the producer side, out in order on
// the consumer side. Full/empty flags come from registered state only (no fall-through).
module tdfc_stream_queue #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_e,
    input  logic              i_v,
    output logic              i_b,
    output logic [WIDTH-1:0]  o_d,
    output logic              o_e,
    output logic              o_v,
    input  logic              o_b,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH:0]    mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W:0]   cnt;
    logic              push;
    logic              pop;

    // i_b looks only at cnt, so a pop on a full queue frees the slot one cycle later.
    assign i_b   = (cnt == FULL_CNT);
    assign o_v   = (cnt != '0);
    assign push  = i_v & ~i_b;
    assign pop   = o_v & ~o_b;
    assign count = cnt;

    assign {o_e, o_d} = mem[rp];

    // NOTE: storage has no reset; stale slots are never visible because o_v gates them,
    // and leaving the array out of reset lets it map onto plain RAM/flops without reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wp] <= {i_e, i_d};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + ADDR_W'(1);
            end
            if (pop) begin
                rp <= rp + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_tdfc_stream_queue.sv
// Directed bench for tdfc_stream_queue: a table of single-cycle vectors with expected
// post-edge outputs, plus hand-written ramp and asynchronous-reset sequences.
module tb_tdfc_stream_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] i_d   = '0;
    logic        i_e   = 1'b0;
    logic        i_v   = 1'b0;
    logic        i_b;
    logic [15:0] o_d;
    logic        o_e;
    logic        o_v;
    logic        o_b   = 1'b0;
    logic [2:0]  count;

    int tests_run = 0;
    int tests_failed = 0;

    tdfc_stream_queue #(.WIDTH(16), .DEPTH(4), .ADDR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .i_d   (i_d),
        .i_e   (i_e),
        .i_v   (i_v),
        .i_b   (i_b),
        .o_d   (o_d),
        .o_e   (o_e),
        .o_v   (o_v),
        .o_b   (o_b),
        .count (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        iv;
        logic        ie;
        logic [15:0] id;
        logic        ob;
        logic        ev;
        logic        ee;
        logic [15:0] ed;
        logic        eb;
        logic [2:0]  ecnt;
        logic        chk_d;
        logic        chk_e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic iv, logic ie, logic [15:0] id, logic ob,
                                logic ev, logic ee, logic [15:0] ed, logic eb,
                                logic [2:0] ecnt, logic chk_d, logic chk_e);
        vec_t v;
        v.name = name; v.iv = iv; v.ie = ie; v.id = id; v.ob = ob;
        v.ev = ev; v.ee = ee; v.ed = ed; v.eb = eb; v.ecnt = ecnt;
        v.chk_d = chk_d; v.chk_e = chk_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic iv, input logic ie, input logic [15:0] id, input logic ob);
        @(negedge clock);
        i_v = iv;
        i_e = ie;
        i_d = id;
        o_b = ob;
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string name, input logic ev, input logic eb,
                               input logic [2:0] ecnt);
        check({name, ".o_v"}, 32'(o_v), 32'(ev));
        check({name, ".i_b"}, 32'(i_b), 32'(eb));
        check({name, ".count"}, 32'(count), 32'(ecnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: single token, one-cycle latency.
        vecs.push_back(mk("t1_push",  1, 0, 16'h0011, 0, 1, 0, 16'h0011, 0, 3'd1, 1, 1));
        vecs.push_back(mk("t1_drain", 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0));
        // Test 2: fill with consumer stalled; fifth token held off.
        vecs.push_back(mk("t2_p1", 1, 0, 16'h0001, 1, 1, 0, 16'h0001, 0, 3'd1, 1, 1));
        vecs.push_back(mk("t2_p2", 1, 0, 16'h0002, 1, 1, 0, 16'h0001, 0, 3'd2, 1, 1));
        vecs.push_back(mk("t2_p3", 1, 0, 16'h0003, 1, 1, 0, 16'h0001, 0, 3'd3, 1, 1));
        vecs.push_back(mk("t2_p4", 1, 0, 16'h0004, 1, 1, 0, 16'h0001, 1, 3'd4, 1, 1));
        vecs.push_back(mk("t2_p5_held", 1, 0, 16'h0005, 1, 1, 0, 16'h0001, 1, 3'd4, 1, 1));
        // Test 3: full, o_b=0 and i_v=1 together: pop only, i_b drops next cycle.
        vecs.push_back(mk("t3_full_pop", 1, 0, 16'h0005, 0, 1, 0, 16'h0002, 0, 3'd3, 1, 1));
        vecs.push_back(mk("t2_p5_in",    1, 0, 16'h0005, 0, 1, 0, 16'h0003, 0, 3'd3, 1, 1));
        vecs.push_back(mk("t2_out4",     0, 0, 16'h0000, 0, 1, 0, 16'h0004, 0, 3'd2, 1, 1));
        vecs.push_back(mk("t2_out5",     0, 0, 16'h0000, 0, 1, 0, 16'h0005, 0, 3'd1, 1, 1));
        vecs.push_back(mk("t2_empty",    0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0));
        // Test 5: data, EOS, data; EOS data field is don't-care.
        vecs.push_back(mk("t5_aa",   1, 0, 16'h00AA, 0, 1, 0, 16'h00AA, 0, 3'd1, 1, 1));
        vecs.push_back(mk("t5_eos",  1, 1, 16'hDEAD, 0, 1, 1, 16'h0000, 0, 3'd1, 0, 1));
        vecs.push_back(mk("t5_bb",   1, 0, 16'h00BB, 0, 1, 0, 16'h00BB, 0, 3'd1, 1, 1));
        vecs.push_back(mk("t5_done", 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0));

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_state("reset", 1'b0, 1'b0, 3'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_state("post_reset", 1'b0, 1'b0, 3'd0);

        foreach (vecs[k]) begin
            step(vecs[k].iv, vecs[k].ie, vecs[k].id, vecs[k].ob);
            check_state(vecs[k].name, vecs[k].ev, vecs[k].eb, vecs[k].ecnt);
            if (vecs[k].chk_e) check({vecs[k].name, ".o_e"}, 32'(o_e), 32'(vecs[k].ee));
            if (vecs[k].chk_d) check({vecs[k].name, ".o_d"}, 32'(o_d), 32'(vecs[k].ed));
        end

        // Test 4: streaming push/pop; each head is the token pushed on that same edge.
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b0, 16'h0100 + 16'(n), 1'b0);
            check_state($sformatf("t4_ramp%0d", n), 1'b1, 1'b0, 3'd1);
            check($sformatf("t4_ramp%0d.o_d", n), 32'(o_d), 32'h0100 + 32'(n));
        end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check_state("t4_drain", 1'b0, 1'b0, 3'd0);

        // Test 6: asynchronous reset with 3 tokens queued.
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b0, 16'h0070 + 16'(n), 1'b1);
        end
        check_state("t6_loaded", 1'b1, 1'b0, 3'd3);
        @(negedge clock);
        i_v = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_state("t6_async_rst", 1'b0, 1'b0, 3'd0);
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 1'b0, 16'h0042, 1'b1);
        check_state("t6_first", 1'b1, 1'b0, 3'd1);
        check("t6_first.o_d", 32'(o_d), 32'h0042);
        step(1'b1, 1'b0, 16'h0043, 1'b0);
        check_state("t6_pop42", 1'b1, 1'b0, 3'd1);
        check("t6_pop42.o_d", 32'(o_d), 32'h0043);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
